// File: rtl/orion_types_pkg.sv
// Shared Orion type definitions used by the memory arbiter and its picker.
package orion_types;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_OWNER_IMEM = 1'b0,
    ARB_OWNER_DMEM = 1'b1
  } arb_owner_t;

  // Bit positions of each requester in the req/grant vectors.
  localparam int unsigned ARB_REQ_IMEM = 0;
  localparam int unsigned ARB_REQ_DMEM = 1;

endpackage

// File: rtl/orion_rr_arb2.sv
// Two-way round-robin picker: a lone request always wins, a tie goes to
// whichever requester did not win last time. Purely combinational.
module orion_rr_arb2
  import orion_types::*;
(
  input  logic [1:0] req,
  input  arb_owner_t last_grant,
  output logic [1:0] grant
);

  // One-hot grant selection from the request pair and previous winner.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == ARB_OWNER_IMEM) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/orion_mem_arbiter.sv
// Shares one memory slave port between instruction fetch (imem) and
// load/store (dmem). Requests are registered toward the slave; acks and
// read data are routed combinationally back to the owning master.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ARB_IDLE   | no transaction open; sample both valids, grant one
// ARB_BUSY_I | fetch request presented to slave, waiting for mem_ack
// ARB_BUSY_D | load/store request presented to slave, waiting for mem_ack
module orion_mem_arbiter
  import orion_types::*;
#(
  parameter  int ADDRW = 32,
  parameter  int DATAW = 32,
  localparam int MASKW = DATAW / 8
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic [ADDRW-1:0] imem_addr,
  input  logic             imem_valid,
  output logic [DATAW-1:0] imem_rdata,
  output logic             imem_ack,

  input  logic [ADDRW-1:0] dmem_addr,
  input  logic             dmem_valid,
  input  logic [DATAW-1:0] dmem_wdata,
  input  logic [MASKW-1:0] dmem_mask,
  input  logic             dmem_we,
  output logic [DATAW-1:0] dmem_rdata,
  output logic             dmem_ack,

  output logic [ADDRW-1:0] mem_addr,
  output logic             mem_valid,
  output logic [DATAW-1:0] mem_wdata,
  output logic [MASKW-1:0] mem_mask,
  output logic             mem_we,
  input  logic [DATAW-1:0] mem_rdata,
  input  logic             mem_ack
);

  arb_state_t state;
  arb_owner_t last_grant;
  logic [1:0] req;
  logic [1:0] grant;

  assign req[ARB_REQ_IMEM] = imem_valid;
  assign req[ARB_REQ_DMEM] = dmem_valid;

  orion_rr_arb2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Grant in IDLE latches the winner's request; completion returns to IDLE.
  // Valid drops during BUSY are ignored: the slave transaction always finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      last_grant <= ARB_OWNER_IMEM;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_mask   <= '0;
      mem_we     <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant[ARB_REQ_DMEM]) begin
            state      <= ARB_BUSY_D;
            last_grant <= ARB_OWNER_DMEM;
            mem_valid  <= 1'b1;
            mem_addr   <= dmem_addr;
            mem_wdata  <= dmem_wdata;
            mem_mask   <= dmem_mask;
            mem_we     <= dmem_we;
          end else if (grant[ARB_REQ_IMEM]) begin
            state      <= ARB_BUSY_I;
            last_grant <= ARB_OWNER_IMEM;
            mem_valid  <= 1'b1;
            mem_addr   <= imem_addr;
            mem_wdata  <= '0;
            mem_mask   <= '1;
            mem_we     <= 1'b0;
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          if (mem_ack) begin
            state     <= ARB_IDLE;
            mem_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ARB_IDLE;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

  // Read data goes to both masters unqualified; only the ack marks it valid.
  // An ack arriving while IDLE never reaches either master.
  assign imem_ack   = (state == ARB_BUSY_I) & mem_ack;
  assign dmem_ack   = (state == ARB_BUSY_D) & mem_ack;
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

endmodule

// File: doc/orion_mem_arbiter.md
Name: orion_mem_arbiter

Overview:
- Shares a single memory port between the instruction-fetch requester (imem) and the load/store requester (dmem) of the Orion core.
- Sits between the IF/MEM stages and the unified memory or cache slave.
- Uses the valid/ack request protocol on all three ports.
- Applies two-way round-robin arbitration and registers all requests to the slave.

Parameters:
ADDRW, 32, address width of all ports
DATAW, 32, data width of all ports; MASKW = DATAW/8 is derived, not overridable

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
imem_addr  input  ADDRW  fetch address
imem_valid  input  1  fetch request; held with address stable until imem_ack
imem_rdata  output  DATAW  fetch data; valid only while imem_ack=1
imem_ack  output  1  one-cycle completion pulse to fetch
dmem_addr  input  ADDRW  load/store address
dmem_valid  input  1  data request; held with all dmem inputs stable until dmem_ack
dmem_wdata  input  DATAW  store data
dmem_mask  input  MASKW  byte enables
dmem_we  input  1  1=store, 0=load
dmem_rdata  output  DATAW  load data; valid only while dmem_ack=1
dmem_ack  output  1  one-cycle completion pulse to data
mem_addr  output  ADDRW  slave address (registered)
mem_valid  output  1  slave request (registered)
mem_wdata  output  DATAW  slave write data (registered)
mem_mask  output  MASKW  slave byte enables (registered)
mem_we  output  1  slave write enable (registered)
mem_rdata  input  DATAW  slave read data
mem_ack  input  1  slave completion pulse, one cycle

Behaviour:
- Reset values (async on rst_n=0): state=IDLE; mem_valid=0; mem_addr, mem_wdata, mem_mask=0; mem_we=0; last_grant=IMEM.
- imem_ack and dmem_ack are combinational. They are 0 whenever state=IDLE.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, no valid: stay in IDLE; mem_valid=0.
- IDLE, only imem_valid: latch the imem request and go to BUSY_I. Latched values: mem_addr=imem_addr, mem_we=0, mem_mask=all ones, mem_wdata=0.
- IDLE, only dmem_valid: latch the dmem fields and go to BUSY_D.
- IDLE, both valid: grant the requester that is not last_grant. After reset, the first tie goes to dmem.
- On any grant: last_grant <= winner, and mem_valid is 1 from the next cycle.
- BUSY_x, mem_ack=0: hold all mem_* outputs stable and keep mem_valid=1.
- BUSY_x, mem_ack=1: in the same cycle, the owner's ack=1 and its rdata=mem_rdata. The non-owner's ack stays 0. Next cycle: mem_valid=0, state=IDLE.
- Latency: a request seen in IDLE at cycle N gives mem_valid=1 at N+1. The earliest ack to the master is at N+1.
- There is one mandatory IDLE cycle between transactions, so the best-case throughput is one transaction per 2 cycles.
- Masters must drop valid, or present a new request, in the cycle after their ack. IDLE samples valid fresh, so no duplicate grant occurs.
- rdata to a non-owner: drive mem_rdata unconditionally. Only ack qualifies it.
- A master dropping valid mid-transaction is a protocol violation. The arbiter still completes the slave transaction, pulses the owner's ack, and ignores the drop.
- mem_ack while in IDLE is spurious: ignore it, with no ack to either master.
- rst_n asserted mid-transaction: mem_valid drops asynchronously, and the pending request is lost. Masters are also reset.
- No timeout. A slave that never acks stalls both masters indefinitely.

Decomposition:
- Add to the shared orion_types package:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D}
  - typedef enum logic arb_owner_t {ARB_OWNER_IMEM, ARB_OWNER_DMEM}
- One natural sub-module: orion_rr_arb2, a purely combinational two-way picker. Inputs: req[1:0], last_grant. Outputs: grant one-hot. The FSM, request registers and ack routing stay in orion_mem_arbiter.

Test Plan:
- Reset check: hold rst_n=0 while imem_valid=1 -> mem_valid=0 and no ack. Release reset -> mem_valid=1 one cycle later with mem_addr=imem_addr.
- Fetch-only read: imem_addr=0x0000_0100 at cycle 0; slave acks at cycle 3 with mem_rdata=0x0000_0013 -> mem_we=0, mem_mask=4'hF; imem_ack=1 and imem_rdata=0x13 at cycle 3 only; mem_valid=0 at cycle 4.
- Store forwarding: dmem_addr=0x8000_0004, wdata=0xDEAD_BEEF, mask=4'b0011, we=1 -> all four values appear on mem_* one cycle later and stay stable across 5 wait cycles; dmem_ack aligns with mem_ack; imem_ack stays 0.
- Tie after reset: imem_valid=dmem_valid=1 held continuously, slave acks immediately -> grant order is D, I, D, I, and each master's ack count is 2 after 8 cycles.
- Back-to-back fetch under load: both masters continuously valid -> imem is never starved longer than one dmem transaction.
- Spurious ack: mem_ack=1 while in IDLE -> imem_ack=dmem_ack=0 and the state stays IDLE. Separately, assert rst_n=0 during BUSY_D -> mem_valid falls asynchronously, before the next clk edge.
